// File: rtl/mmu_pkg.sv
// Shared MMU constants and width helpers for FIFO counters and addresses.
// Used by the MMU FIFO (see mmu_sync_fifo for the MMU_FIFO_OUT_REG_EN build option).
package mmu_pkg;

  localparam int MMU_DATA_WIDTH = 32;
  localparam int MMU_FIFO_DEPTH = 8;

  // Occupancy must represent 0..depth inclusive, hence depth+1.
  function automatic int mmu_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int mmu_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mmu_fifo_ptr.sv
// Wrapping FIFO address counter 0..DEPTH-1; one-cycle update, clear has priority over increment.
// Never stalls; the caller gates inc_i.
module mmu_fifo_ptr
  import mmu_pkg::*;
#(
  parameter int DEPTH = MMU_FIFO_DEPTH,
  localparam int AW = mmu_addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o
);

  // Explicit wrap compare so non-power-of-2 depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o <= '0;
    end else if (clr_i) begin
      addr_o <= '0;
    end else if (inc_i) begin
      addr_o <= (addr_o == AW'(DEPTH - 1)) ? '0 : addr_o + AW'(1);
    end
  end

endmodule

// File: rtl/mmu_sync_fifo.sv
// Single-clock MMU FIFO with count, thresholds, flush and sticky errors; show-ahead read, or 1-cycle
// registered read when MMU_FIFO_OUT_REG_EN is defined. Push refused when full, pop refused when empty.
module mmu_sync_fifo
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = MMU_DATA_WIDTH,
  parameter int FIFO_DEPTH = MMU_FIFO_DEPTH,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  localparam int CW = mmu_cnt_w(FIFO_DEPTH),
  localparam int AW = mmu_addr_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         count_o,
  input  logic                  clr_err_i,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         count_q;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ovf_ev;
  logic                  unf_ev;

  assign full_o         = (count_q == CW'(FIFO_DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));
  assign count_o        = count_q;

  // Flush swallows the cycle's requests entirely, including their error side effects.
  assign push_acc = wren_i & ~full_o & ~flush_i;
  assign pop_acc  = rden_i & ~empty_o & ~flush_i;
  assign ovf_ev   = wren_i & full_o & ~flush_i;
  assign unf_ev   = rden_i & empty_o & ~flush_i;

  mmu_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_i),
    .inc_i  (push_acc),
    .addr_o (wr_addr)
  );

  mmu_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_i),
    .inc_i  (pop_acc),
    .addr_o (rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A fresh error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (overflow_o & ~clr_err_i) | ovf_ev;
      underflow_o <= (underflow_o & ~clr_err_i) | unf_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_addr] <= wdata_i;
    end
  end

`ifdef MMU_FIFO_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else if (pop_acc) begin
      rdata_o  <= mem[rd_addr];
      rvalid_o <= 1'b1;
    end else begin
      rvalid_o <= 1'b0;
    end
  end
`else
  // Masked while empty so the port never shows stale or uninitialised storage.
  assign rdata_o  = empty_o ? '0 : mem[rd_addr];
  assign rvalid_o = ~empty_o;
`endif

endmodule
